// File: rtl/ecd_request_arbiter.sv
// ecd_request_arbiter: round-robin share of the single ECD request/response stream, one transaction outstanding
module ecd_request_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_mode,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic [1:0]             rsp_resp,
  output logic [511:0]           AXIS_OUT_TDATA,
  output logic                   AXIS_OUT_TVALID,
  input  logic                   AXIS_OUT_TREADY,
  input  logic [255:0]           AXIS_IN_TDATA,
  input  logic                   AXIS_IN_TVALID,
  output logic                   AXIS_IN_TREADY,
  output logic                   timeout_err,
  output logic [7:0]             stale_count
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t r_state, w_state_nxt;
  logic [GW-1:0]      r_last_grant, w_grant;
  logic [31:0]        r_addr, r_data, r_rsp_data;
  logic               r_mode, r_out_valid, r_in_ready, r_timeout_err;
  logic [TW-1:0]      r_timer;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [1:0]         r_rsp_resp;
  logic [7:0]         r_stale;
  logic               w_hs_req, w_in_hs, w_match, w_timeout;
  // Descending scan so the nearest requester after last_grant wins
  always_comb begin
    w_grant = r_last_grant;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[GW'((int'(r_last_grant) + k) % NUM_REQ)]) w_grant = GW'((int'(r_last_grant) + k) % NUM_REQ);
  end
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (r_state == IDLE) && (w_grant == GW'(i));
  end
  assign w_hs_req  = (r_state == IDLE) && req_valid[w_grant];
  assign w_in_hs   = AXIS_IN_TVALID && r_in_ready;
  assign w_match   = w_in_hs && (r_state == WAIT) && (AXIS_IN_TDATA[31:0] == r_addr);
  assign w_timeout = (r_state == WAIT) && !w_match && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? (w_hs_req ? SEND : IDLE) :
                  (r_state == SEND) ? ((r_out_valid && AXIS_OUT_TREADY) ? WAIT : SEND) :
                  ((w_match || w_timeout) ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_last_grant  <= GW'(NUM_REQ - 1);
      r_addr        <= '0;
      r_data        <= '0;
      r_mode        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_in_ready    <= 1'b1;
      r_timer       <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_resp    <= '0;
      r_timeout_err <= 1'b0;
      r_stale       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= '0;
      if (w_hs_req) begin
        r_addr       <= req_addr[32*w_grant +: 32];
        r_data       <= req_data[32*w_grant +: 32];
        r_mode       <= req_mode[w_grant];
        r_last_grant <= w_grant;
        r_out_valid  <= 1'b1;
        r_in_ready   <= 1'b0;
      end
      if (r_state == SEND && r_out_valid && AXIS_OUT_TREADY) begin
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
        r_timer     <= '0;
      end else if (r_state == WAIT) r_timer <= r_timer + 1'b1;
      if (w_match || w_timeout) begin
        r_rsp_valid[r_last_grant] <= 1'b1;
        r_rsp_data <= w_match ? AXIS_IN_TDATA[63:32] : 32'hDEAD_DEAD;
        r_rsp_resp <= w_match ? AXIS_IN_TDATA[65:64] : 2'd2;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_in_hs && !w_match && r_stale != 8'hFF) r_stale <= r_stale + 8'd1;
    end
  end
  assign AXIS_OUT_TDATA  = {8'h01, 439'd0, r_mode, r_data, r_addr};
  assign AXIS_OUT_TVALID = r_out_valid;
  assign AXIS_IN_TREADY  = r_in_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_resp        = r_rsp_resp;
  assign timeout_err     = r_timeout_err;
  assign stale_count     = r_stale;
endmodule

// File: tb/tb_ecd_request_arbiter.sv
// tb_ecd_request_arbiter: random requesters and ECD responder checked against a transaction-level model
module tb_ecd_request_arbiter;
  localparam int N = 3;
  localparam int T = 16;
  logic           clk = 1'b0, resetn = 1'b0;
  logic [N-1:0]   req_valid = '0, req_mode = '0, req_ready, rsp_valid;
  logic [32*N-1:0] req_addr = '0, req_data = '0;
  logic [31:0]    rsp_data;
  logic [1:0]     rsp_resp;
  logic [511:0]   AXIS_OUT_TDATA;
  logic           AXIS_OUT_TVALID, AXIS_OUT_TREADY = 1'b0;
  logic [255:0]   AXIS_IN_TDATA = '0;
  logic           AXIS_IN_TVALID = 1'b0, AXIS_IN_TREADY, timeout_err;
  logic [7:0]     stale_count;
  always #5 clk = ~clk;
  ecd_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_mode(req_mode), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
    .AXIS_OUT_TREADY(AXIS_OUT_TREADY), .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TVALID(AXIS_IN_TVALID),
    .AXIS_IN_TREADY(AXIS_IN_TREADY), .timeout_err(timeout_err), .stale_count(stale_count));
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Transaction-level model: phase 0 idle, 1 request offered, 2 awaiting response
  int          m_ph, m_last, m_wait, m_stale;
  logic [31:0] m_addr, m_data, m_rd;
  logic        m_mode, m_err;
  logic [N-1:0] m_rv;
  logic [1:0]  m_rr;
  logic [N-1:0] pend = '0;
  logic [31:0] pa [N], pd [N];
  logic        pm [N];
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic m_reset();
    m_ph = 0; m_last = N - 1; m_wait = 0; m_stale = 0; m_err = 1'b0;
    m_rv = '0; m_rd = '0; m_rr = '0; m_addr = '0; m_data = '0; m_mode = 1'b0;
  endtask
  task automatic check_all();
    int g;
    logic [N-1:0] er;
    logic [511:0] pkt;
    g = pick(req_valid, m_last);
    er = '0;
    if (m_ph == 0 && g >= 0) er[g] = 1'b1;
    chk("ready", 512'(req_ready & req_valid), 512'(er));
    chk("rsp_valid", 512'(rsp_valid), 512'(m_rv));
    chk("rsp_data", 512'(rsp_data), 512'(m_rd));
    chk("rsp_resp", 512'(rsp_resp), 512'(m_rr));
    chk("out_tvalid", 512'(AXIS_OUT_TVALID), 512'(m_ph == 1));
    chk("in_tready", 512'(AXIS_IN_TREADY), 512'(m_ph != 1));
    chk("timeout_err", 512'(timeout_err), 512'(m_err));
    chk("stale_count", 512'(stale_count), 512'(m_stale));
    if (m_ph == 1) begin
      pkt = '0;
      pkt[31:0] = m_addr; pkt[63:32] = m_data; pkt[64] = m_mode; pkt[511:504] = 8'h01;
      chk("out_tdata", AXIS_OUT_TDATA, pkt);
    end
  endtask
  task automatic step();
    int g;
    logic hs_in, match;
    g = pick(req_valid, m_last);
    hs_in = AXIS_IN_TVALID && m_ph != 1;
    match = hs_in && m_ph == 2 && AXIS_IN_TDATA[31:0] == m_addr;
    m_rv = '0;
    if (hs_in && !match && m_stale < 255) m_stale++;
    if (m_ph == 0 && g >= 0) begin
      m_addr = pa[g]; m_data = pd[g]; m_mode = pm[g]; m_last = g; m_ph = 1; pend[g] = 1'b0;
    end else if (m_ph == 1 && AXIS_OUT_TREADY) begin
      m_ph = 2; m_wait = 0;
    end else if (m_ph == 2) begin
      if (match) begin
        m_rv[m_last] = 1'b1; m_rd = AXIS_IN_TDATA[63:32]; m_rr = AXIS_IN_TDATA[65:64]; m_ph = 0;
      end else if (m_wait == T - 1) begin
        m_rv[m_last] = 1'b1; m_rd = 32'hDEAD_DEAD; m_rr = 2'd2; m_err = 1'b1; m_ph = 0;
      end else m_wait++;
    end
  endtask
  // ph: 0 normal, 1 silent responder, 2 flood of mismatching responses, 3 heavy backpressure
  task automatic drive(input int ph);
    logic [255:0] d;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(2) == 0) begin
        pend[i] = 1'b1; pa[i] = $urandom; pd[i] = $urandom; pm[i] = 1'($urandom_range(1));
      end else if (pend[i] && $urandom_range(49) == 0) pend[i] = 1'b0;
      req_addr[32*i +: 32] = pa[i];
      req_data[32*i +: 32] = pd[i];
      req_mode[i] = pm[i];
    end
    req_valid = pend;
    AXIS_OUT_TREADY = (ph == 3) ? ($urandom_range(9) == 0) : ($urandom_range(9) < 7);
    AXIS_IN_TVALID = (ph == 1) ? 1'b0 : (ph == 2) ? 1'b1 : ($urandom_range(9) < 3);
    for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
    if (ph != 2 && $urandom_range(9) < 7) d[31:0] = m_addr;
    AXIS_IN_TDATA = d;
  endtask
  initial begin
    logic hit;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; pm[i] = 1'b0; end
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_all();
    resetn = 1'b1;
    for (int ph = 0; ph < 4; ph++)
      repeat (1500) begin
        drive(ph);
        #1 check_all();
        step();
        @(negedge clk);
      end
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      drive(0);
      #1 check_all();
      if (m_ph == 1) begin
        hit = 1'b1;
        resetn = 1'b0;
      end else step();
      @(negedge clk);
    end
    chk("reset_in_send_reached", 512'(hit), 512'(1));
    if (hit) begin
      m_reset();
      #1 check_all();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
